// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter
//   state_t    - arbiter FSM state encoding
//   PORT_CORE  - port id of the core load/store unit
//   PORT_DMA   - port id of the DMA/debug master
//   WORD_BYTES - access size in bytes; WORD_LSB is its alignment bit count
package dmem_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;
   localparam logic PORT_CORE  = 1'b0;
   localparam logic PORT_DMA   = 1'b1;
   localparam int   WORD_BYTES = 4;
   localparam int   WORD_LSB   = $clog2(WORD_BYTES);
endpackage

// File: rtl/dmem_bounds_check.sv
// dmem_bounds_check: combinational fault test of one word access against a capability window
//   addr  - byte address of the access
//   base  - inclusive window start
//   limit - exclusive window end
//   fault - misaligned, below base, or running past limit
module dmem_bounds_check
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] limit,
   output logic              fault
);
   // One extra bit so an access at the top of the address space cannot wrap to pass.
   logic [ADDR_W:0] end_addr;
   assign end_addr = {1'b0, addr} + (ADDR_W + 1)'(WORD_BYTES);
   assign fault = |addr[WORD_LSB-1:0] || addr < base || end_addr > {1'b0, limit};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported DataMemory
//   req_*          - per-port request channel (valid/ready, we, addr, wdata); port 0 core, port 1 DMA
//   resp_*         - per-port response channel (valid/ready, rdata, err)
//   bnd_base/limit - per-port capability window [base, limit)
//   mem_*          - one-cycle DataMemory strobes, address, write data, combinational read data
//   busy           - high while a transaction is in flight
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_we,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   output logic [1:0]             req_ready,
   output logic [1:0]             resp_valid,
   input  logic [1:0]             resp_ready,
   output logic [1:0][DATA_W-1:0] resp_rdata,
   output logic [1:0]             resp_err,
   input  logic [1:0][ADDR_W-1:0] bnd_base,
   input  logic [1:0][ADDR_W-1:0] bnd_limit,
   output logic                   mem_re,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   busy
);
   state_t            state, state_nxt;
   logic              last_grant, win, accept, fault;
   logic              port_q, we_q, fault_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   // On contention the port not granted last wins; otherwise the lone valid port.
   assign win = &req_valid ? ~last_grant : req_valid[1];
   // rst_n keeps req_ready low while reset is held even though the FSM sits in IDLE.
   assign accept = rst_n && state == S_IDLE && |req_valid;

   dmem_bounds_check #(.ADDR_W(ADDR_W)) u_bounds (
      .addr  (req_addr[win]),
      .base  (bnd_base[win]),
      .limit (bnd_limit[win]),
      .fault (fault)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = state == S_IDLE   ? (accept ? S_ACCESS : S_IDLE) :
                  state == S_ACCESS ? S_RESP :
                  state == S_RESP && !resp_ready[port_q] ? S_RESP : S_IDLE;

   always_comb begin
      req_ready     = {2{accept}} & {win, ~win};
      mem_re        = state == S_ACCESS && !we_q && !fault_q;
      mem_we        = state == S_ACCESS && we_q && !fault_q;
      resp_valid    = {2{state == S_RESP}} & {port_q, ~port_q};
      resp_rdata[0] = resp_valid[0] ? rdata_q : '0;
      resp_rdata[1] = resp_valid[1] ? rdata_q : '0;
      resp_err      = {2{fault_q}} & resp_valid;
      busy          = state != S_IDLE;
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Stores and faulted accesses leave the response data at zero.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last_grant <= PORT_DMA;
         port_q     <= PORT_CORE;
         we_q       <= 1'b0;
         fault_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else if (accept) begin
         last_grant <= win;
         port_q     <= win;
         we_q       <= req_we[win];
         fault_q    <= fault;
         addr_q     <= req_addr[win];
         wdata_q    <= req_wdata[win];
         rdata_q    <= '0;
      end else if (state == S_ACCESS)
         rdata_q <= mem_re ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter
//   Drives directed and randomized transactions; expectations come from the window/alignment
//   rules, a round-robin grant model and a simple address-derived memory model.
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] MK = 32'h5A5A_A5A5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] req_valid = '0;
   logic [1:0] req_we = '0;
   logic [1:0] resp_ready = '0;
   logic [1:0][AW-1:0] req_addr = '0;
   logic [1:0][AW-1:0] bnd_base = '0;
   logic [1:0][AW-1:0] bnd_limit = '0;
   logic [1:0][DW-1:0] req_wdata = '0;
   logic [1:0] req_ready, resp_valid, resp_err;
   logic [1:0][DW-1:0] resp_rdata;
   logic mem_re, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic fix_en = 1'b0;
   logic [31:0] fix_val = '0;
   logic mdl_last = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   int strobes = 0;

   logic obs_acc, obs_re, obs_we, obs_busy, obs_stable;
   logic [1:0] obs_ready, obs_rv, obs_err;
   logic [31:0] obs_maddr, obs_mwdata, obs_rdata, obs_other;
   int obs_strobes;

   always #5 clk = ~clk;

   assign mem_rdata = fix_en ? fix_val : mem_addr ^ MK;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .bnd_base   (bnd_base),
      .bnd_limit  (bnd_limit),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   always @(negedge clk) begin
      if (mem_re | mem_we) begin
         strobes++;
         n_tests++;
         if ((mem_re & mem_we) | !busy) begin
            n_fail++;
            $display("FAIL strobe_excl: re=%b we=%b busy=%b, expected one strobe while busy", mem_re, mem_we, busy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = '0;
      resp_ready = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mdl_last = 1'b1;
   endtask

   // Runs one transaction on port p and records what the DUT did at each stage.
   task automatic txn(input logic p, input logic we, input logic [31:0] a, wd, b, l,
                      input int hold, input logic other_valid);
      int s0;
      @(posedge clk);
      #1;
      req_valid[p] = 1'b1;
      req_we[p] = we;
      req_addr[p] = a;
      req_wdata[p] = wd;
      bnd_base[p] = b;
      bnd_limit[p] = l;
      req_valid[~p] = other_valid;
      resp_ready[p] = 1'b0;
      obs_acc = 1'b0;
      for (int i = 0; i < 8 && !obs_acc; i++) begin
         @(negedge clk);
         if (req_ready[p]) obs_acc = 1'b1;
      end
      obs_ready = req_ready;
      @(posedge clk);
      #1 req_valid[p] = 1'b0;
      s0 = strobes;
      @(negedge clk);
      obs_re = mem_re;
      obs_we = mem_we;
      obs_maddr = mem_addr;
      obs_mwdata = mem_wdata;
      obs_busy = busy;
      @(negedge clk);
      obs_rv = resp_valid;
      obs_rdata = resp_rdata[p];
      obs_other = resp_rdata[~p];
      obs_err = resp_err;
      obs_stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (resp_valid !== obs_rv || resp_rdata[p] !== obs_rdata || resp_err !== obs_err || req_ready !== 2'b00)
            obs_stable = 1'b0;
      end
      resp_ready[p] = 1'b1;
      @(posedge clk);
      #1 resp_ready[p] = 1'b0;
      obs_strobes = strobes - s0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      req_we = 2'b01;
      req_addr[0] = 32'h10;
      req_addr[1] = 32'h20;
      bnd_base = '0;
      bnd_limit = {32'h100, 32'h100};
      repeat (2) @(negedge clk);
      n_tests++;
      if ({req_ready, resp_valid, resp_err, mem_re, mem_we, busy} !== 9'd0 || mem_addr !== '0 ||
          mem_wdata !== '0 || resp_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b rv=%b err=%b re=%b we=%b busy=%b addr=%h wdata=%h rdata=%h, expected all 0",
                  req_ready, resp_valid, resp_err, mem_re, mem_we, busy, mem_addr, mem_wdata, resp_rdata);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_first_grant: req_ready=%b expected 01", req_ready);
      end
      apply_reset();
   endtask

   task automatic test_load();
      fix_en = 1'b1;
      fix_val = 32'hDEAD_BEEF;
      txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h100, 0, 1'b0);
      fix_en = 1'b0;
      n_tests++;
      if (!obs_acc || obs_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL load_accept: acc=%b ready=%b expected 1/01", obs_acc, obs_ready);
      end
      n_tests++;
      if ({obs_re, obs_we, obs_busy} !== 3'b101 || obs_maddr !== 32'h10 || obs_strobes != 1) begin
         n_fail++;
         $display("FAIL load_strobe: re=%b we=%b busy=%b addr=%h n=%0d expected 1/0/1/10/1",
                  obs_re, obs_we, obs_busy, obs_maddr, obs_strobes);
      end
      n_tests++;
      if (obs_rv !== 2'b01 || obs_rdata !== 32'hDEAD_BEEF || obs_err !== 2'b00 || obs_other !== '0) begin
         n_fail++;
         $display("FAIL load_resp: rv=%b rdata=%h err=%b other=%h expected 01/deadbeef/00/0",
                  obs_rv, obs_rdata, obs_err, obs_other);
      end
   endtask

   task automatic test_store_bounds();
      logic [31:0] addrs [3] = '{32'h0FC, 32'h0FE, 32'h100};
      logic faults [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] wd;
      for (int i = 0; i < 3; i++) begin
         wd = $urandom;
         txn(1'b1, 1'b1, addrs[i], wd, 32'h0, 32'h100, 0, 1'b0);
         n_tests++;
         if (!obs_acc || {obs_re, obs_we} !== {1'b0, !faults[i]} || obs_strobes != (faults[i] ? 0 : 1) ||
             (!faults[i] && (obs_mwdata !== wd || obs_maddr !== addrs[i]))) begin
            n_fail++;
            $display("FAIL store_strobe[%h]: acc=%b re=%b we=%b n=%0d wdata=%h expected we=%b wdata=%h",
                     addrs[i], obs_acc, obs_re, obs_we, obs_strobes, obs_mwdata, !faults[i], wd);
         end
         n_tests++;
         if (obs_rv !== 2'b10 || obs_err !== {faults[i], 1'b0} || obs_rdata !== '0) begin
            n_fail++;
            $display("FAIL store_resp[%h]: rv=%b err=%b rdata=%h expected 10/%b0/0",
                     addrs[i], obs_rv, obs_err, obs_rdata, faults[i]);
         end
      end
   endtask

   task automatic test_wrap();
      txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
      n_tests++;
      if (obs_strobes != 0 || obs_err !== 2'b01 || obs_rdata !== '0 || obs_rv !== 2'b01) begin
         n_fail++;
         $display("FAIL wrap_top: n=%0d err=%b rdata=%h rv=%b expected 0/01/0/01", obs_strobes, obs_err, obs_rdata, obs_rv);
      end
      txn(1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 1'b0);
      n_tests++;
      if (obs_strobes != 1 || obs_err !== 2'b00 || obs_rdata !== (32'hFFFF_FFF8 ^ MK)) begin
         n_fail++;
         $display("FAIL wrap_ok: n=%0d err=%b rdata=%h expected 1/00/%h", obs_strobes, obs_err, obs_rdata, 32'hFFFF_FFF8 ^ MK);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_we[1] = 1'b0;
      req_addr[1] = 32'h44;
      bnd_base[1] = '0;
      bnd_limit[1] = 32'h100;
      txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h100, 5, 1'b1);
      n_tests++;
      if (!obs_acc || obs_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_accept: acc=%b ready=%b expected 1/01", obs_acc, obs_ready);
      end
      n_tests++;
      if (!obs_stable || obs_rv !== 2'b01 || obs_rdata !== (32'h40 ^ MK)) begin
         n_fail++;
         $display("FAIL bp_hold: stable=%b rv=%b rdata=%h expected 1/01/%h", obs_stable, obs_rv, obs_rdata, 32'h40 ^ MK);
      end
      @(negedge clk);
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_next_grant: req_ready=%b expected 10", req_ready);
      end
      resp_ready = 2'b11;
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(posedge clk);
      resp_ready = '0;
   endtask

   task automatic test_round_robin();
      int gc[$];
      logic gp[$];
      logic exp;
      apply_reset();
      req_we = '0;
      req_addr[0] = 32'h20;
      req_addr[1] = 32'h24;
      bnd_base = '0;
      bnd_limit = {32'h100, 32'h100};
      resp_ready = 2'b11;
      req_valid = 2'b11;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         n_tests++;
         if (req_ready === 2'b11) begin
            n_fail++;
            $display("FAIL rr_onehot: req_ready=%b expected at most one bit", req_ready);
         end else if (req_ready != 2'b00) begin
            gc.push_back(c);
            gp.push_back(req_ready[1]);
         end
      end
      n_tests++;
      if (gc.size() != 5) begin
         n_fail++;
         $display("FAIL rr_count: %0d grants expected 5", gc.size());
      end
      for (int i = 0; i < gc.size(); i++) begin
         exp = ~mdl_last;
         n_tests++;
         if (gp[i] !== exp || (i == 0 && gc[0] != 0) || (i > 0 && gc[i] - gc[i-1] != 3)) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: port=%b cycle=%0d expected port=%b cycle=%0d", i, gp[i], gc[i], exp, 3 * i);
         end
         mdl_last = exp;
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(posedge clk);
      resp_ready = '0;
   endtask

   task automatic test_random();
      logic p, we, f;
      logic [31:0] a, b, l, wd, exp_rd;
      int hold;
      for (int it = 0; it < 16; it++) begin
         p = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         b = $urandom_range(0, 63) * 4;
         l = b + $urandom_range(0, 40);
         a = b + $urandom_range(0, 48) - 8;
         a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         wd = $urandom;
         hold = $urandom_range(0, 2);
         f = (a % 4 != 0) || (a < b) || ({32'd0, a} + 64'd4 > {32'd0, l});
         exp_rd = (!we && !f) ? a ^ MK : 32'h0;
         txn(p, we, a, wd, b, l, hold, 1'b0);
         n_tests++;
         if (!obs_acc || obs_ready !== (p ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rand_accept[%0d]: acc=%b ready=%b port=%b", it, obs_acc, obs_ready, p);
         end
         n_tests++;
         if ({obs_re, obs_we} !== {!we && !f, we && !f} || obs_strobes != (f ? 0 : 1) ||
             (!f && obs_maddr !== a) || (!f && we && obs_mwdata !== wd)) begin
            n_fail++;
            $display("FAIL rand_mem[%0d]: re=%b we=%b n=%0d addr=%h wdata=%h expected re=%b we=%b addr=%h wdata=%h",
                     it, obs_re, obs_we, obs_strobes, obs_maddr, obs_mwdata, !we && !f, we && !f, a, wd);
         end
         n_tests++;
         if (obs_rv !== (p ? 2'b10 : 2'b01) || obs_rdata !== exp_rd || obs_err !== (p ? {f, 1'b0} : {1'b0, f}) ||
             obs_other !== '0 || !obs_stable) begin
            n_fail++;
            $display("FAIL rand_resp[%0d]: rv=%b rdata=%h err=%b stable=%b expected rdata=%h fault=%b (a=%h b=%h l=%h)",
                     it, obs_rv, obs_rdata, obs_err, obs_stable, exp_rd, f, a, b, l);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      logic ok;
      apply_reset();
      @(posedge clk);
      #1;
      req_valid[0] = 1'b1;
      req_we[0] = 1'b1;
      req_addr[0] = 32'h80;
      req_wdata[0] = 32'hCAFE_0001;
      bnd_base[0] = '0;
      bnd_limit[0] = 32'h100;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rm_accept: req_ready=%b expected 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = '0;
      s0 = strobes;
      n_tests++;
      if (mem_we !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_access: mem_we=%b busy=%b expected 1/1", mem_we, busy);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({req_ready, resp_valid, resp_err, mem_re, mem_we, busy} !== 9'd0 || mem_addr !== '0 ||
          mem_wdata !== '0 || resp_rdata !== '0) begin
         n_fail++;
         $display("FAIL rm_async_clear: ready=%b rv=%b re=%b we=%b busy=%b addr=%h wdata=%h expected all 0",
                  req_ready, resp_valid, mem_re, mem_we, busy, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      resp_ready = 2'b11;
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 2'b00 || busy !== 1'b0) ok = 1'b0;
      end
      n_tests++;
      if (!ok || strobes != s0) begin
         n_fail++;
         $display("FAIL rm_discard: quiet=%b strobes_after=%0d expected 1/0", ok, strobes - s0);
      end
      req_valid = 2'b11;
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rm_first_grant: req_ready=%b expected 01", req_ready);
      end
      req_valid = '0;
      resp_ready = '0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_bounds();
      test_wrap();
      test_backpressure();
      test_round_robin();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
